// File: rtl/skid_reg_32bit.sv
// skid_reg_32bit: two-entry elastic register with valid/ready on both sides.
// in_ready and out_valid come straight from state flops, so no ready path crosses the block.
module skid_reg_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10,
    BAD   = 2'b11
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = ONE;
      end
      ONE: begin
        if (accept && !pop) state_d = TWO;
        else if (pop && !accept) state_d = EMPTY;
      end
      TWO: begin
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Illegal encoding leaves both data registers untouched while recovering.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) main_d = in_data;
      end
      ONE: begin
        if (accept && pop) main_d = in_data;
        else if (accept) skid_d = in_data;
      end
      TWO: begin
        if (pop) main_d = skid_q;
      end
      default: begin
        main_d = main_q;
        skid_d = skid_q;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
  end

endmodule

// File: tb/tb_skid_reg_32bit.sv
// tb_skid_reg_32bit: directed scenario tasks for skid_reg_32bit.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_skid_reg_32bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  int tests_run;
  int fails;

  skid_reg_32bit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_init got v=%b r=%b d=%h want v=0 r=1 d=00000000",
               out_valid, in_ready, out_data);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h0000_0001;
    tick();
    in_data = 32'h0000_0002;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h1) begin
      fails++;
      $display("FAIL reset_prefill got v=%b r=%b d=%h want v=1 r=0 d=00000001",
               out_valid, in_ready, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_async got v=%b r=%b d=%h want v=0 r=1 d=00000000",
               out_valid, in_ready, out_data);
    end
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
      fails++;
      $display("FAIL reset_first_word got v=%b d=%h want v=1 d=12345678",
               out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_drain got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_empty_pop();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL empty_pop[%0d] got v=%b d=%h r=%b want v=0 d=00000000 r=1",
                 i, out_valid, out_data, in_ready);
      end
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data = 32'(i);
      tests_run++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        fails++;
        $display("FAIL stream_word[%0d] got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_single_stall();
    int low_cycles;
    low_cycles = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hA0;
    tick();
    if (in_ready === 1'b0) low_cycles++;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'hA0) begin
      fails++;
      $display("FAIL stall_a0 got v=%b d=%h want v=1 d=000000a0", out_valid, out_data);
    end
    out_ready = 1'b0;
    in_data = 32'hA1;
    tick();
    if (in_ready === 1'b0) low_cycles++;
    tests_run++;
    if (out_data !== 32'hA0 || dut.skid_q !== 32'hA1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold got d=%h skid=%h r=%b want d=000000a0 skid=000000a1 r=0",
               out_data, dut.skid_q, in_ready);
    end
    out_ready = 1'b1;
    in_data = 32'hA2;
    tick();
    if (in_ready === 1'b0) low_cycles++;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'hA1) begin
      fails++;
      $display("FAIL stall_a1 got v=%b d=%h want v=1 d=000000a1", out_valid, out_data);
    end
    tick();
    in_valid = 1'b0;
    if (in_ready === 1'b0) low_cycles++;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'hA2) begin
      fails++;
      $display("FAIL stall_a2 got v=%b d=%h want v=1 d=000000a2", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (low_cycles !== 1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_ready_low got %0d cycles v=%b want 1 cycle v=0",
               low_cycles, out_valid);
    end
  endtask

  task automatic test_fill_hold();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    tick();
    in_data = 32'hCAFE_F00D;
    tests_run++;
    if (in_ready !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL fill_first got r=%b d=%h want r=1 d=deadbeef", in_ready, out_data);
    end
    tick();
    in_data = 32'h5555_5555;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full got r=%b want 0", in_ready);
    end
    tick();
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || out_data !== 32'hDEAD_BEEF || dut.skid_q !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL fill_held got r=%b d=%h skid=%h want r=0 d=deadbeef skid=cafef00d",
               in_ready, out_data, dut.skid_q);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_data !== 32'hCAFE_F00D || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_pop1 got d=%h r=%b want d=cafef00d r=1", out_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h5555_5555) begin
      fails++;
      $display("FAIL fill_pop2 got v=%b d=%h want v=1 d=55555555", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_accept_pop();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11;
    tick();
    in_data = 32'h22;
    out_ready = 1'b1;
    tests_run++;
    if (out_data !== 32'h11) begin
      fails++;
      $display("FAIL ap_first got d=%h want 00000011", out_data);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'h22 ||
        dut.state_q !== 2'b01) begin
      fails++;
      $display("FAIL ap_swap got v=%b r=%b d=%h st=%b want v=1 r=1 d=00000022 st=01",
               out_valid, in_ready, out_data, dut.state_q);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ap_drain got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    test_reset();
    test_empty_pop();
    test_stream();
    test_single_stall();
    test_fill_hold();
    test_accept_pop();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
